// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control unit: state encoding, opcodes, bus IDs
// and the control_bus field layout.
package cpu_ctrl_pkg;

    localparam int unsigned BUS_ID_W = 5;
    localparam int unsigned AMID_W   = 2;
    localparam int unsigned ALU_OP_W = 5;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned CTRL_W   = 20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_E0   = 3'd3,
        ST_E1   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h2;
    localparam logic [OPC_W-1:0] OP_STA = 4'h3;
    localparam logic [OPC_W-1:0] OP_ALU = 4'h4;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
    localparam logic [OPC_W-1:0] OP_JCC = 4'h6;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    localparam logic [BUS_ID_W-1:0] ID_IR0 = 5'd0;
    localparam logic [BUS_ID_W-1:0] ID_IR1 = 5'd1;
    localparam logic [BUS_ID_W-1:0] ID_A   = 5'd2;
    localparam logic [BUS_ID_W-1:0] ID_B   = 5'd3;
    localparam logic [BUS_ID_W-1:0] ID_MEM = 5'd4;
    localparam logic [BUS_ID_W-1:0] ID_R0  = 5'd5;
    localparam logic [BUS_ID_W-1:0] ID_R1  = 5'd6;
    localparam logic [BUS_ID_W-1:0] ID_PC0 = 5'd9;
    localparam logic [BUS_ID_W-1:0] ID_PC1 = 5'd10;
    localparam logic [BUS_ID_W-1:0] ID_SR  = 5'd17;
    localparam logic [BUS_ID_W-1:0] ID_ALU = 5'd18;

    localparam logic [AMID_W-1:0] AMID_PC   = 2'd0;
    localparam logic [AMID_W-1:0] AMID_R0R1 = 2'd3;

    // Field order, MSB first, is the control_bus bit layout.
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_opcode;
        logic [BUS_ID_W-1:0] mid;
        logic [BUS_ID_W-1:0] sid;
        logic [AMID_W-1:0]   amid;
        logic                pc_inr;
        logic                mid_en;
        logic                sid_en;
    } ctrl_t;

    function automatic logic is_undef_op(input logic [OPC_W-1:0] op);
        return (op >= 4'h7) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/cpu_control_unit_decode.sv
// Combinational decode of (state, IR0, status) into control_bus fields and branch flags.
// CU_ILLEGAL_TRAP_EN: undefined opcodes request HALT and flag illegal_op.
module cu_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [7:0]  ir0,
    input  logic [3:0]  status,
    output ctrl_t       ctrl,
    output logic        branch_e1,
    output logic        branch_halt,
    output logic        illegal_op
);

    logic [OPC_W-1:0] opcode;
    logic [3:0]       sub;
    logic             taken;

    assign opcode = ir0[7:4];
    assign sub    = ir0[3:0];
    assign taken  = status[sub[1:0]] ^ sub[2];

`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal_op = is_undef_op(opcode);
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        ctrl        = '0;
        branch_e1   = 1'b0;
        branch_halt = 1'b0;
        case (state)
            ST_F0, ST_F1: begin
                ctrl.amid   = AMID_PC;
                ctrl.mid    = ID_MEM;
                ctrl.sid    = (state == ST_F0) ? ID_IR0 : ID_IR1;
                ctrl.mid_en = 1'b1;
                ctrl.sid_en = 1'b1;
                ctrl.pc_inr = 1'b1;
            end
            ST_E0: begin
                case (opcode)
                    OP_NOP: ;
                    OP_LDI: begin
                        ctrl.mid    = ID_IR1;
                        ctrl.sid    = {1'b0, sub};
                        ctrl.mid_en = 1'b1;
                        ctrl.sid_en = 1'b1;
                    end
                    OP_LDA: begin
                        ctrl.amid   = AMID_R0R1;
                        ctrl.mid    = ID_MEM;
                        ctrl.sid    = ID_A;
                        ctrl.mid_en = 1'b1;
                        ctrl.sid_en = 1'b1;
                    end
                    OP_STA: begin
                        ctrl.amid   = AMID_R0R1;
                        ctrl.mid    = ID_A;
                        ctrl.sid    = ID_MEM;
                        ctrl.mid_en = 1'b1;
                        ctrl.sid_en = 1'b1;
                    end
                    OP_ALU: begin
                        ctrl.alu_opcode = {1'b0, sub};
                        ctrl.mid        = ID_ALU;
                        ctrl.sid        = ID_A;
                        ctrl.mid_en     = 1'b1;
                        ctrl.sid_en     = 1'b1;
                    end
                    OP_JMP, OP_JCC: begin
                        // Unconditional jump shares the taken-branch path.
                        if (opcode == OP_JMP || taken) begin
                            ctrl.mid    = ID_R0;
                            ctrl.sid    = ID_PC0;
                            ctrl.mid_en = 1'b1;
                            ctrl.sid_en = 1'b1;
                            branch_e1   = 1'b1;
                        end
                    end
                    OP_HLT: branch_halt = 1'b1;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        branch_halt = 1'b1;
`endif
                    end
                endcase
            end
            ST_E1: begin
                ctrl.mid    = ID_R1;
                ctrl.sid    = ID_PC1;
                ctrl.mid_en = 1'b1;
                ctrl.sid_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired fetch/execute micro-sequencer driving the CPU control bus.
// CU_ILLEGAL_TRAP_EN: when defined, undefined opcodes trap into HALT with illegal=1.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hlt,
    input  logic [15:0] instr,
    input  logic [3:0]  status,
    output logic [19:0] control_bus,
    output logic [3:0]  T,
    output logic        halted,
    output logic        illegal
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   branch_e1;
    logic   branch_halt;
    logic   illegal_op;
    logic   unused_ir1;

    // IR1 is only ever a bus source ID, never decoded.
    assign unused_ir1 = ^instr[15:8];

    cu_decode u_decode (
        .state       (state),
        .ir0         (instr[7:0]),
        .status      (status),
        .ctrl        (ctrl),
        .branch_e1   (branch_e1),
        .branch_halt (branch_halt),
        .illegal_op  (illegal_op)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (!hlt) state_next = ST_F0;
            ST_F0:   state_next = ST_F1;
            ST_F1:   state_next = ST_E0;
            ST_E0: begin
                if (branch_halt)    state_next = ST_HALT;
                else if (branch_e1) state_next = ST_E1;
                else if (hlt)       state_next = ST_IDLE;
                else                state_next = ST_F0;
            end
            ST_E1:   state_next = hlt ? ST_IDLE : ST_F0;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        T = '0;
        case (state)
            ST_F0:   T = 4'b0001;
            ST_F1:   T = 4'b0010;
            ST_E0:   T = 4'b0100;
            ST_E1:   T = 4'b1000;
            default: T = '0;
        endcase
    end

    assign control_bus = ctrl;
    assign halted      = (state == ST_HALT);
    // IR is not rewritten after HALT, so the trapping opcode is still visible.
    assign illegal     = halted & illegal_op;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Table-driven directed bench for cpu_control_unit, plus hand sequences for
// hlt parking, asynchronous reset abort and HALT.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hlt = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [3:0]  status = 4'h0;
    logic [19:0] control_bus;
    logic [3:0]  T;
    logic        halted;
    logic        illegal;

    int unsigned n_vec = 0;
    int unsigned n_fail = 0;

    cpu_control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .hlt         (hlt),
        .instr       (instr),
        .status      (status),
        .control_bus (control_bus),
        .T           (T),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hlt;
        logic [15:0] instr;
        logic [3:0]  status;
        logic [19:0] bus;
        logic [3:0]  t;
        logic        halted;
        logic        illegal;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] cb(input logic [4:0] alu, input logic [4:0] mid,
                                       input logic [4:0] sid, input logic [1:0] amid,
                                       input logic pc, input logic men, input logic sen);
        return {alu, mid, sid, amid, pc, men, sen};
    endfunction

    function automatic void add(input logic h, input logic [15:0] ins, input logic [3:0] st,
                                input logic [19:0] bus, input logic [3:0] t,
                                input logic hd, input logic il);
        vec_t v;
        v.hlt = h; v.instr = ins; v.status = st; v.bus = bus;
        v.t = t; v.halted = hd; v.illegal = il;
        vecs.push_back(v);
    endfunction

    task automatic compare(input string name, input logic [25:0] got, input logic [25:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got bus=%05h T=%b halted=%b illegal=%b, expected bus=%05h T=%b halted=%b illegal=%b",
                     name, got[25:6], got[5:2], got[1], got[0], exp[25:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check before the next rising edge.
    task automatic step(input string name, input logic h, input logic [15:0] ins,
                        input logic [3:0] st, input logic [19:0] bus, input logic [3:0] t,
                        input logic hd, input logic il);
        @(negedge clk);
        hlt = h; instr = ins; status = st;
        #1;
        compare(name, {control_bus, T, halted, illegal}, {bus, t, hd, il});
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        reset = 1'b0; hlt = 1'b0;
        #1;
        compare("reset_held", {control_bus, T, halted, illegal}, 26'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare("reset_release_idle", {control_bus, T, halted, illegal}, 26'd0);
    endtask

    logic [19:0] bf0, bf1, b0;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        bf0 = cb(5'd0, 5'd4, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        bf1 = cb(5'd0, 5'd4, 5'd1, 2'd0, 1'b1, 1'b1, 1'b1);
        b0  = 20'd0;

        // LDI sub=2
        add(0, 16'h5A12, 4'h0, bf0, 4'b0001, 0, 0);
        add(0, 16'h5A12, 4'h0, bf1, 4'b0010, 0, 0);
        add(0, 16'h5A12, 4'h0, cb(0, 1, 2, 0, 0, 1, 1), 4'b0100, 0, 0);
        // ALU sub=3
        add(0, 16'h0043, 4'h0, bf0, 4'b0001, 0, 0);
        add(0, 16'h0043, 4'h0, bf1, 4'b0010, 0, 0);
        add(0, 16'h0043, 4'h0, cb(3, 18, 2, 0, 0, 1, 1), 4'b0100, 0, 0);
        // Jcc sub=1, status[1]=1: taken
        add(0, 16'h0061, 4'b0010, bf0, 4'b0001, 0, 0);
        add(0, 16'h0061, 4'b0010, bf1, 4'b0010, 0, 0);
        add(0, 16'h0061, 4'b0010, cb(0, 5, 9, 0, 0, 1, 1), 4'b0100, 0, 0);
        add(0, 16'h0061, 4'b0010, cb(0, 6, 10, 0, 0, 1, 1), 4'b1000, 0, 0);
        // Jcc sub=1, status=0: not taken
        add(0, 16'h0061, 4'b0000, bf0, 4'b0001, 0, 0);
        add(0, 16'h0061, 4'b0000, bf1, 4'b0010, 0, 0);
        add(0, 16'h0061, 4'b0000, b0, 4'b0100, 0, 0);
        // Jcc sub=6 (inverted status[2]=0): taken
        add(0, 16'h0066, 4'b0000, bf0, 4'b0001, 0, 0);
        add(0, 16'h0066, 4'b0000, bf1, 4'b0010, 0, 0);
        add(0, 16'h0066, 4'b0000, cb(0, 5, 9, 0, 0, 1, 1), 4'b0100, 0, 0);
        add(0, 16'h0066, 4'b0000, cb(0, 6, 10, 0, 0, 1, 1), 4'b1000, 0, 0);
        // Jcc sub=4 (inverted status[0]=1): not taken
        add(0, 16'h0064, 4'b0001, bf0, 4'b0001, 0, 0);
        add(0, 16'h0064, 4'b0001, bf1, 4'b0010, 0, 0);
        add(0, 16'h0064, 4'b0001, b0, 4'b0100, 0, 0);
        // LDA
        add(0, 16'h0020, 4'h0, bf0, 4'b0001, 0, 0);
        add(0, 16'h0020, 4'h0, bf1, 4'b0010, 0, 0);
        add(0, 16'h0020, 4'h0, cb(0, 4, 2, 3, 0, 1, 1), 4'b0100, 0, 0);
        // STA
        add(0, 16'h0030, 4'h0, bf0, 4'b0001, 0, 0);
        add(0, 16'h0030, 4'h0, bf1, 4'b0010, 0, 0);
        add(0, 16'h0030, 4'h0, cb(0, 2, 4, 3, 0, 1, 1), 4'b0100, 0, 0);
        // NOP with hlt raised in F1: park in IDLE, resume after release
        add(0, 16'h0000, 4'h0, bf0, 4'b0001, 0, 0);
        add(1, 16'h0000, 4'h0, bf1, 4'b0010, 0, 0);
        add(1, 16'h0000, 4'h0, b0, 4'b0100, 0, 0);
        add(1, 16'h0000, 4'h0, b0, 4'b0000, 0, 0);
        add(0, 16'h0000, 4'h0, b0, 4'b0000, 0, 0);
        // Undefined opcode 0x7
        add(0, 16'h0070, 4'h0, bf0, 4'b0001, 0, 0);
        add(0, 16'h0070, 4'h0, bf1, 4'b0010, 0, 0);
        add(0, 16'h0070, 4'h0, b0, 4'b0100, 0, 0);
`ifdef CU_ILLEGAL_TRAP_EN
        add(0, 16'h0070, 4'h0, b0, 4'b0000, 1, 1);
        add(0, 16'h0070, 4'h0, b0, 4'b0000, 1, 1);
`else
        add(0, 16'h0070, 4'h0, bf0, 4'b0001, 0, 0);
        add(0, 16'h0070, 4'h0, bf1, 4'b0010, 0, 0);
`endif

        rst_cycle();
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].hlt, vecs[i].instr, vecs[i].status,
                 vecs[i].bus, vecs[i].t, vecs[i].halted, vecs[i].illegal);
        end

        // JMP with hlt held from F0: instruction still completes through E1, then IDLE
        rst_cycle();
        step("jmp_f0_hlt",   1, 16'h0050, 4'h0, bf0, 4'b0001, 0, 0);
        step("jmp_f1_hlt",   1, 16'h0050, 4'h0, bf1, 4'b0010, 0, 0);
        step("jmp_e0_hlt",   1, 16'h0050, 4'h0, cb(0, 5, 9, 0, 0, 1, 1), 4'b0100, 0, 0);
        step("jmp_e1_hlt",   1, 16'h0050, 4'h0, cb(0, 6, 10, 0, 0, 1, 1), 4'b1000, 0, 0);
        step("jmp_idle",     0, 16'h0050, 4'h0, b0, 4'b0000, 0, 0);
        step("jmp2_f0",      0, 16'h0050, 4'h0, bf0, 4'b0001, 0, 0);
        step("jmp2_f1",      0, 16'h0050, 4'h0, bf1, 4'b0010, 0, 0);
        step("jmp2_e0",      0, 16'h0050, 4'h0, cb(0, 5, 9, 0, 0, 1, 1), 4'b0100, 0, 0);
        // Asynchronous reset in the middle of E0
        reset = 1'b0;
        #1;
        compare("async_reset_abort", {control_bus, T, halted, illegal}, 26'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare("abort_release_idle", {control_bus, T, halted, illegal}, 26'd0);

        // HLT: terminal HALT, illegal stays low
        step("hlt_f0",   0, 16'h00F0, 4'h0, bf0, 4'b0001, 0, 0);
        step("hlt_f1",   0, 16'h00F0, 4'h0, bf1, 4'b0010, 0, 0);
        step("hlt_e0",   0, 16'h00F0, 4'h0, b0, 4'b0100, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("halt_hold%0d", k), 0, 16'h00F0, 4'h0, b0, 4'b0000, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
